// File: rtl/mmio_fifo_pkg.sv
// Shared definitions for the MMIO FIFO controller.
//   - Register offsets (MMIO word offsets from BASE_ADDR)
//   - STATUS bit positions and CTRL bit positions
//   - Read-response record type
package mmio_fifo_pkg;

  localparam int TID_W  = 9;
  localparam int DATA_W = 64;

  // Word offsets inside the four-register window
  localparam logic [15:0] OFF_DATA   = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0002;
  localparam logic [15:0] OFF_CTRL   = 16'h0004;
  localparam logic [15:0] OFF_THRESH = 16'h0006;

  // STATUS layout (count occupies the low CW bits)
  localparam int ST_EMPTY     = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_AFULL     = 18;
  localparam int ST_OVERFLOW  = 19;
  localparam int ST_UNDERFLOW = 20;

  // CTRL bits
  localparam int CTRL_FLUSH     = 0;
  localparam int CTRL_CLR_STICKY = 1;

  typedef struct packed {
    logic              valid;
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] data;
  } t_mmio_rsp;

endpackage

// File: rtl/mmio_fifo_mem.sv
// DEPTH x 64 storage for the MMIO FIFO.
//   clk      clock
//   wr_en    write strobe, wr_addr/wr_data written on the rising edge
//   rd_en    read strobe; rd_data is registered (read-before-write), so a
//            pop and a push to the same slot in one cycle returns old data
//   rd_addr  read address, sampled on the rising edge
//   rd_data  data for the address sampled on the previous edge
module mmio_fifo_mem
  import mmio_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; its contents are only observable after a
  // push, and a reset term would prevent mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO-mapped FIFO controller.
// Decodes MMIO reads/writes in a four-register window at BASE_ADDR
// (DATA, STATUS, CTRL, THRESH) and drives a circular 64-bit buffer.
//   clk, rst        clock, asynchronous active-high reset
//   mmio_wr_valid   write strobe
//   mmio_rd_valid   read strobe
//   mmio_addr       MMIO word address
//   mmio_tid        read TID, echoed in the response
//   mmio_wdata      write data
//   rsp_valid       one-cycle response strobe, only for window hits
//   rsp_tid         echoed TID
//   rsp_data        response data
//   almost_full     registered count >= thresh
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mmio_wr_valid,
  input  logic              mmio_rd_valid,
  input  logic [15:0]       mmio_addr,
  input  logic [TID_W-1:0]  mmio_tid,
  input  logic [DATA_W-1:0] mmio_wdata,
  output logic              rsp_valid,
  output logic [TID_W-1:0]  rsp_tid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]       off;
  logic              sel_data, sel_status, sel_ctrl, sel_thresh, rd_hit;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, thresh;
  logic              overflow, underflow, af_q;
  logic              empty, full;
  logic              pop_req, push_req, pop_ok, push_ok;
  logic              ovf_set, udf_set, flush, clr_sticky;
  logic [DATA_W-1:0] reg_rdata, mem_rdata;
  t_mmio_rsp         rsp_q;
  logic              rsp_from_mem_q;

  // Offset wraps for addresses below BASE_ADDR, so they fall outside the window.
  assign off        = mmio_addr - BASE_ADDR;
  assign sel_data   = (off == OFF_DATA);
  assign sel_status = (off == OFF_STATUS);
  assign sel_ctrl   = (off == OFF_CTRL);
  assign sel_thresh = (off == OFF_THRESH);
  assign rd_hit     = mmio_rd_valid && (sel_data || sel_status || sel_ctrl || sel_thresh);

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Pop is judged on pre-cycle state; a pop on a full FIFO frees the slot
  // that a same-cycle push then fills.
  assign pop_req    = mmio_rd_valid && sel_data;
  assign push_req   = mmio_wr_valid && sel_data;
  assign pop_ok     = pop_req && !empty;
  assign udf_set    = pop_req && empty;
  assign push_ok    = push_req && (!full || pop_ok);
  assign ovf_set    = push_req && !push_ok;
  assign flush      = mmio_wr_valid && sel_ctrl && mmio_wdata[CTRL_FLUSH];
  assign clr_sticky = mmio_wr_valid && sel_ctrl && mmio_wdata[CTRL_CLR_STICKY];

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    reg_rdata = '0;
    if (sel_status) begin
      reg_rdata[CW-1:0]        = count;
      reg_rdata[ST_EMPTY]      = empty;
      reg_rdata[ST_FULL]       = full;
      reg_rdata[ST_AFULL]      = af_q;
      reg_rdata[ST_OVERFLOW]   = overflow;
      reg_rdata[ST_UNDERFLOW]  = underflow;
    end else if (sel_thresh) begin
      reg_rdata[CW-1:0] = thresh;
    end
  end

  mmio_fifo_mem #(.DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (mmio_wdata),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      thresh    <= CW'(DEPTH);
      overflow  <= 1'b0;
      underflow <= 1'b0;
      af_q      <= 1'b0;
    end else begin
      if (flush) begin
        // Stored data is left in place; only the bookkeeping is cleared.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        count <= count + CW'(push_ok) - CW'(pop_ok);
      end
      if (mmio_wr_valid && sel_thresh) thresh <= mmio_wdata[CW-1:0];
      // Clear first so a same-cycle set wins.
      if (clr_sticky) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (ovf_set) overflow  <= 1'b1;
      if (udf_set) underflow <= 1'b1;
      af_q <= (count >= thresh);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q          <= '0;
      rsp_from_mem_q <= 1'b0;
    end else begin
      rsp_q.valid    <= rd_hit;
      rsp_from_mem_q <= pop_ok;
      if (rd_hit) begin
        rsp_q.tid  <= mmio_tid;
        rsp_q.data <= reg_rdata;   // zero for DATA pops; replaced by memory data when the pop succeeded
      end
    end
  end

  assign rsp_valid   = rsp_q.valid;
  assign rsp_tid     = rsp_q.tid;
  assign rsp_data    = rsp_from_mem_q ? mem_rdata : rsp_q.data;
  assign almost_full = af_q;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Self-checking bench for mmio_fifo_ctrl (DEPTH=8, BASE_ADDR=0x20).
module tb_mmio_fifo_ctrl;

  localparam logic [15:0] A_DATA   = 16'h0020;
  localparam logic [15:0] A_STATUS = 16'h0022;
  localparam logic [15:0] A_CTRL   = 16'h0024;
  localparam logic [15:0] A_THRESH = 16'h0026;
  localparam logic [15:0] A_OUT    = 16'h0028;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_wr_valid, mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        almost_full;

  int tests_run = 0;
  int tests_failed = 0;

  mmio_fifo_ctrl #(.DEPTH(8), .BASE_ADDR(16'h0020)) dut (
    .clk           (clk),
    .rst           (rst),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_addr     (mmio_addr),
    .mmio_tid      (mmio_tid),
    .mmio_wdata    (mmio_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_tid       (rsp_tid),
    .rsp_data      (rsp_data),
    .almost_full   (almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [8:0]  tid;
    logic        exp_valid;
    logic [63:0] exp_data;
    int          exp_af;     // -1: not checked
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic rd, input logic [15:0] addr,
                     input logic [63:0] wdata, input logic ev, input logic [63:0] ed,
                     input int af);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
    v.tid = 9'(vecs.size() + 9'h040);
    v.exp_valid = ev; v.exp_data = ed; v.exp_af = af;
    vecs.push_back(v);
  endtask

  task automatic rd_v(input logic [15:0] addr, input logic [63:0] ed, input int af);
    add(1'b0, 1'b1, addr, 64'h0, 1'b1, ed, af);
  endtask

  task automatic wr_v(input logic [15:0] addr, input logic [63:0] wd, input int af);
    add(1'b1, 1'b0, addr, wd, 1'b0, 64'h0, af);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [63:0] wd, input logic [8:0] tid);
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = addr;
    mmio_wdata    = wd;
    mmio_tid      = tid;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset rsp_tid", 64'(rsp_tid), 64'h0);
    check("reset rsp_data", rsp_data, 64'h0);
    check("reset almost_full", 64'(almost_full), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and decode
    rd_v(A_STATUS, 64'h10000, 0);
    add(1'b0, 1'b1, A_OUT, 64'h0, 1'b0, 64'h0, -1);
    rd_v(A_CTRL, 64'h0, -1);
    rd_v(A_THRESH, 64'h8, -1);
    // Fill, then overflow; almost_full rises the cycle after count reaches 8
    for (int i = 1; i <= 8; i++) wr_v(A_DATA, 64'hA0 + 64'(i), (i == 8) ? 0 : -1);
    wr_v(A_DATA, 64'hA9, 1);
    rd_v(A_STATUS, 64'hE0008, -1);
    for (int i = 1; i <= 8; i++) rd_v(A_DATA, 64'hA0 + 64'(i), -1);
    // Underflow, then clear sticky flags
    rd_v(A_DATA, 64'h0, -1);
    rd_v(A_STATUS, 64'h190000, 0);
    wr_v(A_CTRL, 64'h2, -1);
    rd_v(A_STATUS, 64'h10000, -1);
    // Pointer wrap
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) wr_v(A_DATA, 64'hB00 + 64'(16 * r + i), -1);
      for (int i = 0; i < 3; i++) rd_v(A_DATA, 64'hB00 + 64'(16 * r + i), -1);
    end
    rd_v(A_STATUS, 64'h10000, -1);
    // Full FIFO, same-cycle push and pop
    for (int i = 0; i < 8; i++) wr_v(A_DATA, 64'hC0 + 64'(i), -1);
    add(1'b1, 1'b1, A_DATA, 64'hD0, 1'b1, 64'hC0, -1);
    rd_v(A_STATUS, 64'h60008, 1);
    for (int i = 1; i < 8; i++) rd_v(A_DATA, 64'hC0 + 64'(i), -1);
    rd_v(A_DATA, 64'hD0, -1);
    rd_v(A_STATUS, 64'h10000, 0);
    // Empty FIFO, same-cycle push and pop
    add(1'b1, 1'b1, A_DATA, 64'hE0, 1'b1, 64'h0, -1);
    rd_v(A_STATUS, 64'h100001, -1);
    wr_v(A_CTRL, 64'h2, -1);
    rd_v(A_DATA, 64'hE0, -1);
    // Threshold: upper bits dropped, almost_full one cycle after third push
    wr_v(A_THRESH, 64'hFFFF_FFFF_FFFF_FFF3, -1);
    rd_v(A_THRESH, 64'h3, 0);
    wr_v(A_DATA, 64'hF1, 0);
    wr_v(A_DATA, 64'hF2, 0);
    wr_v(A_DATA, 64'hF3, 0);
    add(1'b0, 1'b0, A_DATA, 64'h0, 1'b0, 64'h0, 1);
    rd_v(A_STATUS, 64'h40003, 1);
    // Head read then flush; thresh survives the flush
    rd_v(A_DATA, 64'hF1, -1);
    wr_v(A_CTRL, 64'h1, -1);
    rd_v(A_STATUS, 64'h10000, 0);
    rd_v(A_THRESH, 64'h3, -1);
    add(1'b1, 1'b1, A_CTRL, 64'h3, 1'b1, 64'h0, -1);
    // Ignored writes and misses
    wr_v(A_STATUS, 64'hFFFF, -1);
    wr_v(16'h001E, 64'h1234, -1);
    wr_v(A_OUT, 64'h5678, -1);
    rd_v(A_STATUS, 64'h10000, -1);
    add(1'b0, 1'b1, 16'h0021, 64'h0, 1'b0, 64'h0, -1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].tid);
      @(posedge clk);
      #1;
      check($sformatf("v%0d rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d rsp_tid", i), 64'(rsp_tid), 64'(vecs[i].tid));
        check($sformatf("v%0d rsp_data", i), rsp_data, vecs[i].exp_data);
      end
      if (vecs[i].exp_af >= 0)
        check($sformatf("v%0d almost_full", i), 64'(almost_full), 64'(vecs[i].exp_af));
    end

    // Async reset drops an already-visible response immediately
    @(negedge clk);
    drive(1'b0, 1'b1, A_STATUS, 64'h0, 9'h155);
    @(posedge clk);
    #1;
    check("pre-reset rsp_valid", 64'(rsp_valid), 64'h1);
    check("pre-reset rsp_data", rsp_data, 64'h10000);
    drive(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
    rst = 1'b1;
    #1;
    check("async reset rsp_valid", 64'(rsp_valid), 64'h0);
    check("async reset rsp_tid", 64'(rsp_tid), 64'h0);
    check("async reset rsp_data", rsp_data, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while a request is in flight: no response, state restored
    @(negedge clk);
    drive(1'b1, 1'b0, A_THRESH, 64'h5, 9'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, A_DATA, 64'h77, 9'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, A_DATA, 64'h0, 9'h0AA);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("pending rsp dropped", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, A_STATUS, 64'h0, 9'h011);
    @(posedge clk);
    #1;
    check("post-reset status", rsp_data, 64'h10000);
    check("post-reset tid", 64'(rsp_tid), 64'h011);
    @(negedge clk);
    drive(1'b0, 1'b1, A_THRESH, 64'h0, 9'h012);
    @(posedge clk);
    #1;
    check("post-reset thresh", rsp_data, 64'h8);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 64'h0, 9'h0);
    @(posedge clk);
    #1;
    check("single-cycle rsp_valid", 64'(rsp_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
